// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, requester IDs
// and the default implemented memory depth.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  localparam int MEM_DEPTH_DEFAULT = 29;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; combinational, the last-served pointer is
// held by the parent. grant[0] = core, grant[1] = DMA.
import mem_ctrl_pkg::*;

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == REQ_DMA) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-ported data memory between the core LSU and the DMA loader:
// round-robin pick in IDLE, one-cycle memory access, registered ack/rdata.
import mem_ctrl_pkg::*;

module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  core_req_in,
  input  logic                  core_we_in,
  input  logic [ADDR_WIDTH-1:0] core_addr_in,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  output logic                  core_ack_out,
  output logic                  core_err_out,
  input  logic                  dma_req_in,
  input  logic                  dma_we_in,
  input  logic [ADDR_WIDTH-1:0] dma_addr_in,
  input  logic [DATA_WIDTH-1:0] dma_data_in,
  output logic                  dma_ack_out,
  output logic                  dma_err_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  busy_out,
  output logic                  mem_write_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  state_t                state;
  logic                  last_served;
  logic                  cmd_id;
  logic                  cmd_we;
  logic                  cmd_err;
  logic                  we_q;
  logic [1:0]            grant;
  logic                  sel_we;
  logic                  sel_err;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter2 u_arb (
    .req   ({dma_req_in, core_req_in}),
    .last  (last_served),
    .grant (grant)
  );

  always_comb begin
    sel_we   = core_we_in;
    sel_addr = core_addr_in;
    sel_data = core_data_in;
    if (grant[1]) begin
      sel_we   = dma_we_in;
      sel_addr = dma_addr_in;
      sel_data = dma_data_in;
    end
    sel_err = 32'(sel_addr) >= 32'(MEM_DEPTH);
  end

  // Reset gates the enable directly so a write caught mid-ACCESS never commits.
  assign mem_write_en_out = we_q & ~rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      last_served  <= REQ_DMA;
      cmd_id       <= REQ_CORE;
      cmd_we       <= 1'b0;
      cmd_err      <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
      rdata_out    <= '0;
      busy_out     <= 1'b0;
      core_ack_out <= 1'b0;
      core_err_out <= 1'b0;
      dma_ack_out  <= 1'b0;
      dma_err_out  <= 1'b0;
    end else begin
      core_ack_out <= 1'b0;
      core_err_out <= 1'b0;
      dma_ack_out  <= 1'b0;
      dma_err_out  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            cmd_id       <= grant[1];
            cmd_we       <= sel_we;
            cmd_err      <= sel_err;
            we_q         <= sel_we & ~sel_err;
            mem_addr_out <= sel_addr;
            mem_data_out <= sel_data;
            busy_out     <= 1'b1;
            state        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          we_q      <= 1'b0;
          rdata_out <= (cmd_we || cmd_err) ? '0 : mem_data_in;
          if (cmd_id == REQ_DMA) begin
            dma_ack_out <= 1'b1;
            dma_err_out <= cmd_err;
          end else begin
            core_ack_out <= 1'b1;
            core_err_out <= cmd_err;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          busy_out    <= 1'b0;
          last_served <= cmd_id;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scenario tests plus a randomized run for data_memory_arbiter, checked against
// a transaction-level model (round-robin pick, shadow memory, range rule).
module tb_data_memory_arbiter;

  localparam int DEPTH = 29;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        core_req_in = 1'b0, core_we_in = 1'b0;
  logic [7:0]  core_addr_in = '0;
  logic [31:0] core_data_in = '0;
  logic        dma_req_in = 1'b0, dma_we_in = 1'b0;
  logic [7:0]  dma_addr_in = '0;
  logic [31:0] dma_data_in = '0;
  logic        core_ack_out, core_err_out, dma_ack_out, dma_err_out;
  logic [31:0] rdata_out;
  logic        busy_out, mem_write_en_out;
  logic [7:0]  mem_addr_out;
  logic [31:0] mem_data_out, mem_data_in;

  logic [31:0] sim_mem [0:255];
  logic [31:0] ref_mem [0:255];
  int checks = 0, errors = 0, we_cnt = 0, overlap_cnt = 0;
  int last_ref = 1;

  data_memory_arbiter dut (
    .clk_in(clk), .rst_in(rst_in),
    .core_req_in(core_req_in), .core_we_in(core_we_in),
    .core_addr_in(core_addr_in), .core_data_in(core_data_in),
    .core_ack_out(core_ack_out), .core_err_out(core_err_out),
    .dma_req_in(dma_req_in), .dma_we_in(dma_we_in),
    .dma_addr_in(dma_addr_in), .dma_data_in(dma_data_in),
    .dma_ack_out(dma_ack_out), .dma_err_out(dma_err_out),
    .rdata_out(rdata_out), .busy_out(busy_out),
    .mem_write_en_out(mem_write_en_out), .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  assign mem_data_in = sim_mem[mem_addr_out];

  always @(posedge clk) begin
    if (mem_write_en_out) begin
      sim_mem[mem_addr_out] <= mem_data_out;
      we_cnt++;
    end
  end

  always @(negedge clk) if (core_ack_out && dma_ack_out) overlap_cnt++;

  // Model helpers: round-robin winner, expected error and read data.
  function automatic int pick(input logic c, input logic d);
    if (c && d) return (last_ref == 1) ? 0 : 1;
    return c ? 0 : 1;
  endfunction

  function automatic logic exp_err(input logic [7:0] a);
    return int'(a) >= DEPTH;
  endfunction

  function automatic logic [31:0] exp_rd(input logic we, input logic [7:0] a);
    if (we || exp_err(a)) return 32'h0;
    return ref_mem[a];
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(output int who, output int cycles, output logic err,
                          output logic [31:0] rd);
    who = -1; cycles = 0; err = 1'b0; rd = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (core_ack_out) begin who = 0; cycles = i; err = core_err_out; rd = rdata_out; break; end
      if (dma_ack_out)  begin who = 1; cycles = i; err = dma_err_out;  rd = rdata_out; break; end
    end
  endtask

  task automatic test_reset();
    int who, cyc; logic err; logic [31:0] rd; int w0;
    rst_in = 1'b1;
    core_req_in = 1; core_we_in = 1; core_addr_in = 8'd4; core_data_in = 32'hA5A5_0004;
    dma_req_in  = 1; dma_we_in  = 1; dma_addr_in  = 8'd6; dma_data_in  = 32'h5A5A_0006;
    w0 = we_cnt;
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      checks++;
      if ({core_ack_out, dma_ack_out, mem_write_en_out, busy_out} !== 4'b0 || rdata_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs acks=%b%b we=%b busy=%b rdata=%h required all 0",
                 core_ack_out, dma_ack_out, mem_write_en_out, busy_out, rdata_out);
      end
    end
    checks++;
    if (we_cnt !== w0) begin errors++; $display("FAIL reset_no_write writes=%0d required 0", we_cnt - w0); end
    rst_in = 1'b0;
    last_ref = 1;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== pick(1, 1) || cyc !== 2) begin
      errors++; $display("FAIL reset_first_grant who=%0d cycles=%0d required 0/2", who, cyc);
    end
    ref_mem[4] = 32'hA5A5_0004; last_ref = 0;
    core_req_in = 0;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== pick(0, 1) || cyc !== 3) begin
      errors++; $display("FAIL reset_second_grant who=%0d cycles=%0d required 1/3", who, cyc);
    end
    ref_mem[6] = 32'h5A5A_0006; last_ref = 1;
    dma_req_in = 0;
    idle_cycle();
  endtask

  task automatic test_write_read();
    int who, cyc; logic err; logic [31:0] rd; int w0;
    idle_cycle();
    w0 = we_cnt;
    core_req_in = 1; core_we_in = 1; core_addr_in = 8'd5; core_data_in = 32'hDEAD_BEEF;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 0 || cyc !== 2 || err !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL write_ack who=%0d cycles=%0d err=%b rdata=%h required 0/2/0/0", who, cyc, err, rd);
    end
    checks++;
    if (we_cnt - w0 !== 1) begin errors++; $display("FAIL write_pulse count=%0d required 1", we_cnt - w0); end
    ref_mem[5] = 32'hDEAD_BEEF; last_ref = 0;
    core_req_in = 0;
    idle_cycle();
    core_req_in = 1; core_we_in = 0;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 0 || err !== 1'b0 || rd !== 32'hDEAD_BEEF || rd !== ref_mem[5]) begin
      errors++; $display("FAIL read_back who=%0d err=%b rdata=%h required 0/0/deadbeef", who, err, rd);
    end
    core_req_in = 0;
    idle_cycle();
  endtask

  task automatic test_out_of_range();
    int who, cyc; logic err; logic [31:0] rd; int w0;
    logic [31:0] m29;
    m29 = sim_mem[29];
    w0 = we_cnt;
    dma_req_in = 1; dma_we_in = 1; dma_addr_in = 8'd29; dma_data_in = 32'h1234_5678;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 1 || err !== exp_err(8'd29) || we_cnt !== w0 || sim_mem[29] !== m29) begin
      errors++; $display("FAIL oor_write who=%0d err=%b writes=%0d required 1/1/0", who, err, we_cnt - w0);
    end
    last_ref = 1; dma_req_in = 0;
    idle_cycle();
    dma_req_in = 1; dma_we_in = 0; dma_addr_in = 8'd28;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 1 || err !== 1'b0 || rd !== exp_rd(1'b0, 8'd28)) begin
      errors++; $display("FAIL oor_read28 err=%b rdata=%h required 0/%h", err, rd, exp_rd(1'b0, 8'd28));
    end
    dma_req_in = 0;
    idle_cycle();
    dma_req_in = 1; dma_addr_in = 8'd200;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_read200 err=%b rdata=%h required 1/0", err, rd);
    end
    dma_req_in = 0;
    idle_cycle();
  endtask

  task automatic test_simultaneous();
    int who, cyc, exp; logic err; logic [31:0] rd;
    int ov0;
    ov0 = overlap_cnt;
    core_req_in = 1; core_we_in = 0; core_addr_in = 8'd1;
    dma_req_in  = 1; dma_we_in  = 0; dma_addr_in  = 8'd2;
    for (int k = 0; k < 4; k++) begin
      exp = pick(1, 1);
      wait_ack(who, cyc, err, rd);
      checks++;
      if (who !== exp || who !== (k % 2) || cyc !== ((k == 0) ? 2 : 3) ||
          rd !== exp_rd(1'b0, (exp == 0) ? 8'd1 : 8'd2)) begin
        errors++; $display("FAIL simul_txn%0d who=%0d cycles=%0d rdata=%h required %0d/%0d", k, who, cyc, rd, exp,
                           (k == 0) ? 2 : 3);
      end
      last_ref = exp;
    end
    core_req_in = 0; dma_req_in = 0;
    idle_cycle();
    checks++;
    if (overlap_cnt !== ov0) begin errors++; $display("FAIL simul_overlap count=%0d required 0", overlap_cnt - ov0); end
  endtask

  task automatic test_reset_mid();
    int w0; logic [31:0] old3; logic ack_seen;
    idle_cycle();
    old3 = ref_mem[3];
    w0 = we_cnt;
    core_req_in = 1; core_we_in = 1; core_addr_in = 8'd3; core_data_in = ~old3;
    idle_cycle();
    checks++;
    if (busy_out !== 1'b1) begin errors++; $display("FAIL rstmid_access busy=%b required 1", busy_out); end
    rst_in = 1'b1;
    #1;
    checks++;
    if (mem_write_en_out !== 1'b0) begin errors++; $display("FAIL rstmid_we_gate we=%b required 0", mem_write_en_out); end
    @(posedge clk); #1;
    rst_in = 1'b0; core_req_in = 0;
    last_ref = 1;
    checks++;
    if (busy_out !== 1'b0 || core_ack_out !== 1'b0 || rdata_out !== 32'h0) begin
      errors++; $display("FAIL rstmid_idle busy=%b ack=%b rdata=%h required 0/0/0", busy_out, core_ack_out, rdata_out);
    end
    ack_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      if (core_ack_out || dma_ack_out) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen || sim_mem[3] !== old3 || we_cnt !== w0) begin
      errors++; $display("FAIL rstmid_no_commit ack=%b mem3=%h required 0/%h", ack_seen, sim_mem[3], old3);
    end
  endtask

  task automatic test_sticky();
    int who, cyc; logic err; logic [31:0] rd;
    core_req_in = 1; core_we_in = 0; core_addr_in = 8'd7;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 0 || cyc !== 2 || rd !== ref_mem[7]) begin
      errors++; $display("FAIL sticky_first who=%0d cycles=%0d required 0/2", who, cyc);
    end
    last_ref = 0;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 0 || cyc !== 3 || rd !== ref_mem[7]) begin
      errors++; $display("FAIL sticky_reserve who=%0d cycles=%0d required 0/3", who, cyc);
    end
    last_ref = 0;
    dma_req_in = 1; dma_we_in = 0; dma_addr_in = 8'd8;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== pick(1, 1) || who !== 1 || cyc !== 3 || rd !== ref_mem[8]) begin
      errors++; $display("FAIL sticky_dma_wins who=%0d cycles=%0d required 1/3", who, cyc);
    end
    last_ref = 1; dma_req_in = 0;
    wait_ack(who, cyc, err, rd);
    checks++;
    if (who !== 0 || cyc !== 3) begin
      errors++; $display("FAIL sticky_core_after who=%0d cycles=%0d required 0/3", who, cyc);
    end
    last_ref = 0; core_req_in = 0;
    idle_cycle();
  endtask

  task automatic test_random();
    int who, cyc, exp; logic err; logic [31:0] rd;
    logic       pend [2];
    logic       p_we [2];
    logic [7:0] p_addr [2];
    logic [31:0] p_data [2];
    int bad = 0;
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 40; it++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && ($urandom_range(0, 1) == 1 || (s == 1 && !pend[0]))) begin
          pend[s] = 1;
          p_we[s] = 1'($urandom_range(0, 1));
          p_addr[s] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(29, 255)) : 8'($urandom_range(0, 31));
          p_data[s] = $urandom;
        end
      end
      core_req_in = pend[0]; core_we_in = p_we[0]; core_addr_in = p_addr[0]; core_data_in = p_data[0];
      dma_req_in  = pend[1]; dma_we_in  = p_we[1]; dma_addr_in  = p_addr[1]; dma_data_in  = p_data[1];
      exp = pick(pend[0], pend[1]);
      wait_ack(who, cyc, err, rd);
      checks++;
      if (who !== exp || cyc !== ((it == 0) ? 2 : 3) || err !== exp_err(p_addr[exp]) ||
          rd !== exp_rd(p_we[exp], p_addr[exp])) begin
        errors++; bad++;
        $display("FAIL random_txn%0d who=%0d cycles=%0d err=%b rdata=%h required %0d/%0d/%b/%h", it, who, cyc,
                 err, rd, exp, (it == 0) ? 2 : 3, exp_err(p_addr[exp]), exp_rd(p_we[exp], p_addr[exp]));
      end
      if (p_we[exp] && !exp_err(p_addr[exp])) ref_mem[p_addr[exp]] = p_data[exp];
      last_ref = exp;
      pend[exp] = 0;
      if (exp == 0) core_req_in = 0; else dma_req_in = 0;
      if (bad > 3) break;
    end
    core_req_in = 0; dma_req_in = 0;
    idle_cycle(); idle_cycle();
    checks++;
    begin
      int diff = 0;
      for (int a = 0; a < 256; a++) if (sim_mem[a] !== ref_mem[a]) diff++;
      if (diff != 0) begin errors++; $display("FAIL random_mem_image differing_words=%0d required 0", diff); end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = $urandom;
      sim_mem[a] = ref_mem[a];
    end
    test_reset();
    test_write_read();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid();
    test_sticky();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-ported 32-bit data memory between the core load/store unit and a DMA/debug loader. It accepts one request per requester, picks a winner round-robin, drives the memory write port and address for exactly one cycle, and returns registered read data with a one-cycle acknowledge. It sits between the core/DMA request buses and the data memory, and owns every memory control signal.

## Interface
- ADDR_WIDTH, 8, word address width (matches memory address port)
- DATA_WIDTH, 32, data word width
- MEM_DEPTH, 29, number of implemented words; addresses >= MEM_DEPTH are out of range
- clk_in  input  1  system clock, all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- core_req_in  input  1  core request; held high until core_ack_out
- core_we_in  input  1  1 = write, 0 = read; stable while core_req_in is high
- core_addr_in  input  ADDR_WIDTH  core word address
- core_data_in  input  DATA_WIDTH  core write data
- core_ack_out  output  1  one-cycle completion pulse
- core_err_out  output  1  valid with core_ack_out; out-of-range address
- dma_req_in, dma_we_in, dma_addr_in, dma_data_in, dma_ack_out, dma_err_out: same as the core_* ports, for the DMA requester
- rdata_out  output  DATA_WIDTH  read data; valid in the ack cycle
- busy_out  output  1  high in ACCESS and RESP
- mem_write_en_out  output  1  to memory write enable
- mem_addr_out  output  ADDR_WIDTH  to memory address
- mem_data_out  output  DATA_WIDTH  to memory write data
- mem_data_in  input  DATA_WIDTH  from memory, combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: if any req_in is high, pick a winner, latch its we/addr/data plus the error flag (addr >= MEM_DEPTH) into a command register, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration: if only one requester is high, it wins. If both are high, the requester that was not served last wins. The last-served pointer resets to DMA, so the core wins the first tie.
- ACCESS: mem_addr_out and mem_data_out come from the command register. mem_write_en_out = latched_we & ~latched_err, so the write commits at the end of ACCESS. At that same edge rdata_out captures mem_data_in, or 0 when latched_err. Then go to RESP.
- RESP: pulse the winner's ack_out, with err_out = latched_err. Update the last-served pointer. Go to IDLE.
- Req inputs are ignored in ACCESS and RESP. A req still high in the cycle after ack is treated as a new request.
- Write requests leave rdata_out at 0. rdata_out holds its value until the next ACCESS completes.
- rst_in in any state forces IDLE and clears all registered state. Reset values: all acks, errs, busy_out and mem_write_en_out are 0; mem_addr_out, mem_data_out and rdata_out are 0; pointer = DMA. An in-flight write in ACCESS that coincides with rst_in is suppressed, because write enable is gated by state != reset.

## Timing
- Request sampled in IDLE at cycle 0: memory access in cycle 1, ack and rdata in cycle 2. Latency is 2 cycles from the sampling edge.
- Maximum throughput is one access per 3 cycles. Back-to-back requests from both sides alternate: core, DMA, core, and so on.
- mem_write_en_out is high for exactly one cycle per accepted write, and never in IDLE or RESP.
- mem_* outputs depend only on registers; there is no combinational path from any req_in.
- Only one ack_out is high in any cycle.

## Structure
- Shared package mem_ctrl_pkg holds:
  - state encoding (IDLE, ACCESS, RESP)
  - requester IDs (REQ_CORE = 0, REQ_DMA = 1)
  - MEM_DEPTH default
- One natural sub-module, rr_arbiter2: two request bits plus the last-served bit in, a one-hot grant out. It is purely combinational and the pointer register lives in the parent.
- The command register, FSM and response register live in data_memory_arbiter.

## Test plan
- Reset: hold rst_in high for 2 cycles with both requests high. Required: no ack, mem_write_en_out = 0, rdata_out = 0. After release, the core is granted first.
- Core write then read: write addr 5 with 0xDEADBEEF, then read addr 5. Required: write ack in cycle 2 with err = 0; read ack with rdata_out = 0xDEADBEEF.
- Simultaneous requests: hold both reqs high for 4 transactions (core addr 1, DMA addr 2). Required: grant order is core, DMA, core, DMA; acks are 3 cycles apart and never overlap.
- Out of range: DMA writes addr 29 with 0x12345678. Required: dma_err_out = 1 with the ack, mem_write_en_out stays 0. A following read of addr 28 is unchanged; a read of addr 200 gives err = 1 and rdata 0.
- Reset mid-operation: assert rst_in during ACCESS of a core write to addr 3. Required: memory word 3 is unchanged, no ack is issued, and the FSM is in IDLE the next cycle.
- Sticky request: core holds req through its ack. Required: it is re-served as a new request. If DMA is also requesting, DMA wins that arbitration.
